// File: rtl/cache_refill_ctrl.sv
// Miss/refill controller: issues a pending write-through to RAM, then fetches the
// missing block word by word and streams the returned words into the cache fill port.
module cache_refill_ctrl #(
  parameter int unsigned RAM_ADDRESS_BITS = 10,
  parameter int unsigned DATA_BITS        = 32,
  parameter int unsigned BLOCK_BITS       = 2
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        miss,
  input  logic [RAM_ADDRESS_BITS-1:0] miss_address,
  input  logic                        wt_en,
  input  logic [RAM_ADDRESS_BITS-1:0] wt_address,
  input  logic [DATA_BITS-1:0]        wt_data,
  output logic                        busy,
  output logic                        ram_req,
  output logic                        ram_we,
  output logic [RAM_ADDRESS_BITS-1:0] ram_address,
  output logic [DATA_BITS-1:0]        ram_wdata,
  input  logic                        ram_ready,
  input  logic                        ram_rvalid,
  input  logic [DATA_BITS-1:0]        ram_rdata,
  output logic                        fill_en,
  output logic [RAM_ADDRESS_BITS-1:0] fill_address,
  output logic [DATA_BITS-1:0]        fill_data,
  output logic                        fill_done
);

  localparam int unsigned AW          = RAM_ADDRESS_BITS;
  localparam int unsigned DW          = DATA_BITS;
  localparam int unsigned BLOCK_WORDS = 1 << BLOCK_BITS;
  localparam int unsigned CNT_W       = BLOCK_BITS + 1;

  typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;

  state_t           state_q, state_d;
  logic [AW-1:0]    base_q, base_d;
  logic [AW-1:0]    wt_addr_q, wt_addr_d;
  logic [DW-1:0]    wt_data_q, wt_data_d;
  logic             miss_pending_q, miss_pending_d;
  logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [CNT_W-1:0] ret_cnt_q, ret_cnt_d;

  logic             busy_d, ram_req_d, ram_we_d, fill_en_d, fill_done_d;
  logic [AW-1:0]    ram_address_d, fill_address_d;
  logic [DW-1:0]    ram_wdata_d, fill_data_d;
  logic             accept;

  // Next state, counters, and the next value of every registered output
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    wt_addr_d      = wt_addr_q;
    wt_data_d      = wt_data_q;
    miss_pending_d = miss_pending_q;
    issue_cnt_d    = issue_cnt_q;
    ret_cnt_d      = ret_cnt_q;
    fill_en_d      = 1'b0;
    fill_done_d    = 1'b0;
    fill_address_d = fill_address;
    fill_data_d    = fill_data;
    ram_req_d      = 1'b0;
    ram_we_d       = 1'b0;
    ram_address_d  = ram_address;
    ram_wdata_d    = ram_wdata;
    accept         = ram_req && ram_ready;

    case (state_q)
      IDLE: begin
        issue_cnt_d = '0;
        ret_cnt_d   = '0;
        if (wt_en) begin
          wt_addr_d      = wt_address;
          wt_data_d      = wt_data;
          miss_pending_d = miss;
          base_d         = miss_address & ~AW'(BLOCK_WORDS - 1);
          state_d        = WRITE;
        end else if (miss) begin
          base_d  = miss_address & ~AW'(BLOCK_WORDS - 1);
          state_d = FILL;
        end
      end
      WRITE: begin
        if (accept) begin
          if (miss_pending_q) begin
            miss_pending_d = 1'b0;
            state_d        = FILL;
          end else begin
            state_d = IDLE;
          end
        end
      end
      FILL: begin
        if (accept) issue_cnt_d = issue_cnt_q + CNT_W'(1);
        // Returns beyond the issued count are protocol errors and are dropped
        if (ram_rvalid && (ret_cnt_q < issue_cnt_q)) begin
          fill_en_d      = 1'b1;
          fill_address_d = base_q | AW'(ret_cnt_q[BLOCK_BITS-1:0]);
          fill_data_d    = ram_rdata;
          ret_cnt_d      = ret_cnt_q + CNT_W'(1);
          if (ret_cnt_q == CNT_W'(BLOCK_WORDS - 1)) begin
            fill_done_d = 1'b1;
            state_d     = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    if (state_d == WRITE) begin
      ram_req_d     = 1'b1;
      ram_we_d      = 1'b1;
      ram_address_d = wt_addr_d;
      ram_wdata_d   = wt_data_d;
    end else if (state_d == FILL) begin
      ram_req_d     = (issue_cnt_d < CNT_W'(BLOCK_WORDS));
      ram_address_d = base_d | AW'(issue_cnt_d[BLOCK_BITS-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      base_q         <= '0;
      wt_addr_q      <= '0;
      wt_data_q      <= '0;
      miss_pending_q <= 1'b0;
      issue_cnt_q    <= '0;
      ret_cnt_q      <= '0;
      busy           <= 1'b0;
      ram_req        <= 1'b0;
      ram_we         <= 1'b0;
      ram_address    <= '0;
      ram_wdata      <= '0;
      fill_en        <= 1'b0;
      fill_address   <= '0;
      fill_data      <= '0;
      fill_done      <= 1'b0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      wt_addr_q      <= wt_addr_d;
      wt_data_q      <= wt_data_d;
      miss_pending_q <= miss_pending_d;
      issue_cnt_q    <= issue_cnt_d;
      ret_cnt_q      <= ret_cnt_d;
      busy           <= busy_d;
      ram_req        <= ram_req_d;
      ram_we         <= ram_we_d;
      ram_address    <= ram_address_d;
      ram_wdata      <= ram_wdata_d;
      fill_en        <= fill_en_d;
      fill_address   <= fill_address_d;
      fill_data      <= fill_data_d;
      fill_done      <= fill_done_d;
    end
  end

endmodule

// File: tb/tb_cache_refill_ctrl.sv
// Scoreboard bench for cache_refill_ctrl: directed misses/write-throughs with
// a latency-2 RAM model; request and fill monitors pop expected entries.
module tb_cache_refill_ctrl;
  localparam int unsigned AW = 10;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          miss = 1'b0;
  logic [AW-1:0] miss_address = '0;
  logic          wt_en = 1'b0;
  logic [AW-1:0] wt_address = '0;
  logic [DW-1:0] wt_data = '0;
  logic          busy, ram_req, ram_we, fill_en, fill_done;
  logic [AW-1:0] ram_address, fill_address;
  logic [DW-1:0] ram_wdata, fill_data;
  logic          ram_ready = 1'b1;
  logic          ram_rvalid = 1'b0;
  logic [DW-1:0] ram_rdata = '0;

  cache_refill_ctrl dut (
    .clk(clk), .reset_n(reset_n), .miss(miss), .miss_address(miss_address),
    .wt_en(wt_en), .wt_address(wt_address), .wt_data(wt_data), .busy(busy),
    .ram_req(ram_req), .ram_we(ram_we), .ram_address(ram_address),
    .ram_wdata(ram_wdata), .ram_ready(ram_ready), .ram_rvalid(ram_rvalid),
    .ram_rdata(ram_rdata), .fill_en(fill_en), .fill_address(fill_address),
    .fill_data(fill_data), .fill_done(fill_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic we; logic [AW-1:0] addr; logic [DW-1:0] data;} req_t;
  typedef struct packed {logic [AW-1:0] addr; logic [DW-1:0] data; logic done;} fill_t;

  req_t          req_q[$];
  fill_t         fill_q[$];
  int            ret_target[$];
  logic [DW-1:0] ret_data[$];

  int            checks = 0, errors = 0;
  int            cyc = 0;
  logic [DW-1:0] data_base = '0;
  int            stall_idx = -1, stall_left = 0, read_idx = 0;
  logic [AW-1:0] stall_addr = '0;
  bit            force_rvalid = 1'b0;
  int            done_cnt = 0, fill_cnt = 0;
  bit            done_prev = 1'b0;

  task automatic check(input bit ok, input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: decides ready/rvalid for the coming posedge and checks accepted requests
  always @(negedge clk) begin
    logic rdy;
    req_t e;
    #2;
    rdy = 1'b1;
    if (reset_n && ram_req && !ram_we && read_idx == stall_idx && stall_left > 0) begin
      rdy = 1'b0;
      stall_left--;
      check(ram_address == stall_addr, "stall_addr_hold", 64'(ram_address), 64'(stall_addr));
    end
    ram_ready = rdy;
    if (reset_n && ram_req && rdy) begin
      check(req_q.size() != 0, "unexpected_req", 64'({ram_we, ram_address}), 64'(0));
      if (req_q.size() != 0) begin
        e = req_q.pop_front();
        check(ram_we == e.we && ram_address == e.addr && (!e.we || ram_wdata == e.data),
              "ram_req", 64'({ram_we, ram_address, ram_wdata}), 64'({e.we, e.addr, e.data}));
      end
      if (!ram_we) begin
        read_idx++;
        ret_target.push_back(cyc + 3);
        ret_data.push_back(data_base + DW'(ram_address[1:0]));
      end
    end
    ram_rvalid = 1'b0;
    while (ret_target.size() != 0 && ret_target[0] < cyc + 1) begin
      void'(ret_target.pop_front());
      void'(ret_data.pop_front());
    end
    if (ret_target.size() != 0 && ret_target[0] == cyc + 1) begin
      void'(ret_target.pop_front());
      ram_rdata  = ret_data.pop_front();
      ram_rvalid = 1'b1;
    end
    if (force_rvalid) begin
      ram_rvalid = 1'b1;
      ram_rdata  = 32'h5555_0000;
    end
  end

  // Fill monitor
  always @(negedge clk) begin
    fill_t e;
    if (done_prev) check(!busy, "busy_after_done", 64'(busy), 64'(0));
    done_prev = 1'b0;
    if (fill_done) check(fill_en, "done_without_fill", 64'(fill_en), 64'(1));
    if (fill_en) begin
      fill_cnt++;
      check(fill_q.size() != 0, "unexpected_fill", 64'({fill_address, fill_data}), 64'(0));
      if (fill_q.size() != 0) begin
        e = fill_q.pop_front();
        check(fill_address == e.addr && fill_data == e.data && fill_done == e.done, "fill",
              64'({fill_done, fill_address, fill_data}), 64'({e.done, e.addr, e.data}));
      end
      if (fill_done) begin
        done_cnt++;
        done_prev = 1'b1;
      end
    end
  end

  task automatic expect_block(input logic [AW-1:0] base, input logic [DW-1:0] d0,
                              input int nfills);
    for (int i = 0; i < 4; i++) req_q.push_back({1'b0, base + AW'(i), 32'h0});
    for (int i = 0; i < nfills; i++) fill_q.push_back({base + AW'(i), d0 + DW'(i), i == 3});
  endtask

  task automatic pulse_miss(input logic [AW-1:0] a);
    @(negedge clk);
    miss = 1'b1;
    miss_address = a;
    @(negedge clk);
    miss = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int exp_done);
    int n;
    n = 0;
    while (n < 300) begin
      @(negedge clk);
      #3;
      n++;
      if (req_q.size() == 0 && fill_q.size() == 0 && !busy) break;
    end
    check(n < 300, {name, "_timeout"}, 64'(n), 64'(300));
    repeat (2) @(negedge clk);
    check(done_cnt == exp_done, {name, "_done_count"}, 64'(done_cnt), 64'(exp_done));
  endtask

  initial begin
    int n;
    // Reset held with miss and rvalid active
    miss = 1'b1;
    force_rvalid = 1'b1;
    repeat (2) @(negedge clk);
    check({busy, ram_req, ram_we, fill_en, fill_done} == 5'b0, "reset_ctrl",
          64'({busy, ram_req, ram_we, fill_en, fill_done}), 64'(0));
    check(ram_address == '0 && ram_wdata == '0 && fill_address == '0 && fill_data == '0,
          "reset_data", 64'({ram_address, fill_address}), 64'(0));
    miss = 1'b0;
    force_rvalid = 1'b0;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    check(!busy && !ram_req, "idle_after_reset", 64'({busy, ram_req}), 64'(0));

    // Basic refill of block 0x0B4
    data_base = 32'hA0; read_idx = 0; done_cnt = 0;
    expect_block(10'h0B4, 32'hA0, 4);
    pulse_miss(10'h0B6);
    wait_idle("basic", 1);

    // Second read held off for 3 cycles
    read_idx = 0; done_cnt = 0; stall_idx = 1; stall_left = 3; stall_addr = 10'h0B5;
    expect_block(10'h0B4, 32'hA0, 4);
    pulse_miss(10'h0B6);
    wait_idle("backpressure", 1);
    check(stall_left == 0, "stall_exercised", 64'(stall_left), 64'(0));
    stall_idx = -1;

    // Write-through with simultaneous miss at the top block
    data_base = 32'hB0; read_idx = 0; done_cnt = 0;
    req_q.push_back({1'b1, 10'h010, 32'hDEADBEEF});
    expect_block(10'h3FC, 32'hB0, 4);
    @(negedge clk);
    wt_en = 1'b1; wt_address = 10'h010; wt_data = 32'hDEADBEEF;
    miss = 1'b1; miss_address = 10'h3FF;
    @(negedge clk);
    wt_en = 1'b0; miss = 1'b0;
    wait_idle("wt_then_miss", 1);

    // Reset after two of four fills
    data_base = 32'hC0; read_idx = 0; done_cnt = 0;
    expect_block(10'h0C0, 32'hC0, 2);
    n = fill_cnt;
    pulse_miss(10'h0C1);
    for (int i = 0; i < 100 && fill_cnt < n + 2; i++) begin
      @(negedge clk);
      #3;
    end
    check(fill_cnt == n + 2, "midfill_two_fills", 64'(fill_cnt - n), 64'(2));
    reset_n = 1'b0;
    req_q.delete();
    repeat (2) @(negedge clk);
    check(!busy && !ram_req && !fill_en, "midfill_reset", 64'({busy, ram_req, fill_en}), 64'(0));
    reset_n = 1'b1;
    force_rvalid = 1'b1;
    repeat (2) @(negedge clk);
    force_rvalid = 1'b0;
    repeat (8) @(negedge clk);
    check(!busy && !ram_req, "midfill_idle", 64'({busy, ram_req}), 64'(0));
    check(done_cnt == 0, "midfill_no_done", 64'(done_cnt), 64'(0));
    data_base = 32'hD0; read_idx = 0;
    expect_block(10'h040, 32'hD0, 4);
    pulse_miss(10'h040);
    wait_idle("after_reset", 1);

    // Stray rvalid in IDLE, then miss/wt_en while busy
    done_cnt = 0;
    force_rvalid = 1'b1;
    repeat (3) @(negedge clk);
    force_rvalid = 1'b0;
    @(negedge clk);
    check(!busy && !ram_req, "stray_rvalid_idle", 64'({busy, ram_req}), 64'(0));
    data_base = 32'hE0; read_idx = 0;
    expect_block(10'h200, 32'hE0, 4);
    pulse_miss(10'h201);
    check(busy, "busy_during_fill", 64'(busy), 64'(1));
    miss = 1'b1; miss_address = 10'h123;
    wt_en = 1'b1; wt_address = 10'h321; wt_data = 32'h1234_5678;
    repeat (3) @(negedge clk);
    miss = 1'b0; wt_en = 1'b0;
    wait_idle("stray_busy", 1);
    repeat (4) @(negedge clk);
    check(!busy && !ram_req, "final_idle", 64'({busy, ram_req}), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running required finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cache_refill_ctrl.md
Name: cache_refill_ctrl

Overview:
- Miss/refill controller directly downstream of the cache.
- Consumes the cache's miss indication and write-through request. Issues the write-through to RAM first, then fetches the whole missing block word by word.
- Streams returned words back to the cache fill port and pulses fill_done when the block is complete.
- Holds busy high while active so upstream stalls.

Parameters:
- RAM_ADDRESS_BITS, 10, word address width of RAM.
- DATA_BITS, 32, data word width.
- BLOCK_BITS, 2, log2 of words per block; BLOCK_WORDS = 2**BLOCK_BITS (4 by default).

Ports:
- clk  in  1  clock; all logic on posedge.
- reset_n  in  1  synchronous, active-low reset.
- miss  in  1  cache miss request, sampled in IDLE only.
- miss_address  in  RAM_ADDRESS_BITS  address that missed.
- wt_en  in  1  write-through request, sampled in IDLE only.
- wt_address  in  RAM_ADDRESS_BITS  write-through address.
- wt_data  in  DATA_BITS  write-through data.
- busy  out  1  controller not idle; upstream must stall.
- ram_req  out  1  RAM request valid.
- ram_we  out  1  1 = write, 0 = read; valid with ram_req.
- ram_address  out  RAM_ADDRESS_BITS  RAM request address.
- ram_wdata  out  DATA_BITS  RAM write data.
- ram_ready  in  1  RAM accepts the request this cycle when ram_req && ram_ready.
- ram_rvalid  in  1  read data valid; returns are in order, any latency ≥1.
- ram_rdata  in  DATA_BITS  read data.
- fill_en  out  1  write fill_data into cache at fill_address.
- fill_address  out  RAM_ADDRESS_BITS  address of the fill word.
- fill_data  out  DATA_BITS  fill word.
- fill_done  out  1  one-cycle pulse when the block is complete.

Behaviour:
- Reset (reset_n=0 at posedge):
  - State → IDLE.
  - busy, ram_req, ram_we, fill_en, fill_done = 0.
  - All address/data outputs = 0.
  - issue_cnt, ret_cnt, miss_pending cleared.
  - Reset mid-operation abandons the transfer immediately; no further RAM requests or fills are made.
- States: IDLE, WRITE, FILL, DONE. busy = (state != IDLE).
- IDLE:
  - wt_en=1: latch wt_address/wt_data; latch miss_pending = miss and base = {miss_address[RAM_ADDRESS_BITS-1:BLOCK_BITS], BLOCK_BITS'b0}; → WRITE.
  - Else miss=1: latch base; → FILL.
  - Write-through has priority over a simultaneous miss. The miss is not lost; it is serviced after the write.
- WRITE:
  - ram_req=1, ram_we=1, ram_address/ram_wdata = latched values, held stable until accepted.
  - On accept: → FILL if miss_pending (then clear it), else → IDLE.
- FILL, issue side:
  - ram_req = (issue_cnt < BLOCK_WORDS); ram_we=0.
  - ram_address = base | issue_cnt[BLOCK_BITS-1:0].
  - issue_cnt (BLOCK_BITS+1 bits) increments on each accept.
  - Multiple reads may be outstanding.
  - While ram_ready=0, address is held stable.
- FILL, return side:
  - On each cycle with ram_rvalid=1 and ret_cnt < issue_cnt: next cycle drive fill_en=1, fill_address = base | ret_cnt[BLOCK_BITS-1:0], fill_data = ram_rdata (registered, latency 1); ret_cnt increments.
  - rvalid in the same cycle as an accept is legal.
  - When the return is for word BLOCK_WORDS-1 → DONE.
- DONE:
  - fill_en=1 for the last word, fill_done=1 in the same cycle.
  - → IDLE next cycle; busy drops that cycle.
- Address arithmetic: base is block-aligned, so word addresses never carry out of the block. Block at top of the address space (e.g. 0x3FC–0x3FF) has no wrap.
- Ignored inputs:
  - ram_rvalid outside FILL, or with ret_cnt == issue_cnt, is ignored (protocol error; must not corrupt counters).
  - miss/wt_en while busy are ignored; upstream is required to stall.
- fill_en is 0 in every cycle other than those above; fill_done is never asserted without fill_en.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with miss=1 and ram_rvalid=1 → all outputs 0, busy=0, no ram_req.
- Basic refill: miss, miss_address=0x0B6; ram_ready=1; rvalid 2 cycles after each accept; rdata=0xA0..0xA3 →
  - reads at 0x0B4, 0x0B5, 0x0B6, 0x0B7 in order;
  - four fill_en pulses with fill_address 0x0B4..0x0B7 and data 0xA0..0xA3;
  - fill_done coincides with the 0x0B7 fill; busy falls next cycle.
- Backpressure: same miss, ram_ready low for 3 cycles on the second read → ram_address stays 0x0B5 and issue_cnt frozen; no duplicate or skipped fills; completes normally.
- Simultaneous events: wt_en (0x010, 0xDEADBEEF) with miss at 0x3FF →
  - first RAM request is a write, ram_we=1 at 0x010 with 0xDEADBEEF;
  - then reads 0x3FC–0x3FF with no wrap to 0x000;
  - fill_done once.
- Reset mid-fill: reset after 2 of 4 fills, then late ram_rvalid pulses → no fill_en, state IDLE; a subsequent miss at 0x040 completes a clean 4-word fill.
- Stray inputs: ram_rvalid in IDLE, and miss pulses while busy → ignored; no extra RAM requests, fills, or fill_done.
